// File: rtl/str_feeder_if.sv
// Byte-stream valid/ready channel into the PE-router feeder.
interface str_feeder_if #(
    parameter int DWIDTH = 8
);
    logic              in_valid;
    logic [DWIDTH-1:0] in_data;
    logic              in_last;
    logic              in_ready;

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready
    );
endinterface

// File: rtl/str_feeder.sv
// Sliding-window feeder for the PE router; collects and reports PE matches.
// Optional STR_FEEDER_STICKY_EN adds sticky_vec, the OR of a stream's results.
module str_feeder #(
    parameter int DWIDTH = 8,
    parameter int num    = 16,
    parameter int PE_LAT = 1,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    str_feeder_if.slave           src_i,
    input  logic                  cfg_we,
    input  logic [num-1:0]        alu_cfg,
    output logic [num*DWIDTH-1:0] str_arr,
    output logic [num-1:0]        ALU,
    output logic [num-1:0]        en,
    output logic                  issue,
    input  logic [num-1:0]        result_from_pe,
    output logic                  match_valid,
    output logic [num-1:0]        match_vec,
    output logic [CNT_W-1:0]      match_pos,
`ifdef STR_FEEDER_STICKY_EN
    output logic [num-1:0]        sticky_vec,
`endif
    output logic                  busy
);
    localparam int DC_W = $clog2(num);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_e;

    state_e                  state_q, state_d;
    logic [DC_W-1:0]         drain_q, drain_d;
    logic                    rdy_q;
    logic [num*DWIDTH-1:0]   win_q, win_d;
    logic [num-1:0]          en_q, en_d;
    logic [num-1:0]          alu_q;
    logic                    issue_q;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        tag_q, tag_d;
    logic [PE_LAT-1:0]       pv_q;
    logic [CNT_W-1:0]        pt_q [PE_LAT];
    logic                    mv_q;
    logic [num-1:0]          mvec_q;
    logic [CNT_W-1:0]        mpos_q;

    logic acc;
    logic shift;
    logic real_b;
    logic first;
    logic tail;

    assign acc  = src_i.in_valid & rdy_q;
    assign tail = pv_q[PE_LAT-1];

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        shift   = 1'b0;
        real_b  = 1'b0;
        first   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (acc) begin
                    shift   = 1'b1;
                    real_b  = 1'b1;
                    first   = 1'b1;
                    drain_d = '0;
                    state_d = src_i.in_last ? DRAIN : FILL;
                end
            end
            FILL: begin
                if (acc) begin
                    shift  = 1'b1;
                    real_b = 1'b1;
                    if (src_i.in_last) begin
                        state_d = DRAIN;
                        drain_d = '0;
                    end
                end
            end
            DRAIN: begin
                // Flush the window, then hold until every issued result is back.
                if (drain_q != DC_W'(num - 1)) begin
                    shift   = 1'b1;
                    drain_d = drain_q + 1'b1;
                end else if (!issue_q && pv_q == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        win_d = win_q;
        en_d  = en_q;
        tag_d = tag_q;
        cnt_d = cnt_q;
        if (shift) begin
            win_d              = win_q << DWIDTH;
            win_d[DWIDTH-1:0]  = real_b ? src_i.in_data : '0;
            en_d               = {en_q[num-2:0], real_b};
        end else if (state_q == DRAIN && state_d == IDLE) begin
            en_d = '0;
        end
        if (acc) begin
            tag_d = first ? '0 : cnt_q;
            cnt_d = tag_d + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            drain_q <= '0;
            rdy_q   <= 1'b0;
            win_q   <= '0;
            en_q    <= '0;
            alu_q   <= '0;
            issue_q <= 1'b0;
            cnt_q   <= '0;
            tag_q   <= '0;
            pv_q    <= '0;
            for (int i = 0; i < PE_LAT; i++) pt_q[i] <= '0;
            mv_q    <= 1'b0;
            mvec_q  <= '0;
            mpos_q  <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            rdy_q   <= (state_d != DRAIN);
            win_q   <= win_d;
            en_q    <= en_d;
            issue_q <= shift;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
            if (cfg_we && state_q == IDLE) alu_q <= alu_cfg;
            pv_q[0] <= issue_q;
            pt_q[0] <= tag_q;
            for (int i = 1; i < PE_LAT; i++) begin
                pv_q[i] <= pv_q[i-1];
                pt_q[i] <= pt_q[i-1];
            end
            mv_q <= tail && (|result_from_pe);
            if (tail && (|result_from_pe)) begin
                mvec_q <= result_from_pe;
                mpos_q <= pt_q[PE_LAT-1];
            end
        end
    end

`ifdef STR_FEEDER_STICKY_EN
    logic [num-1:0] sticky_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_q <= '0;
        end else if (acc && first) begin
            sticky_q <= '0;
        end else if (tail) begin
            sticky_q <= sticky_q | result_from_pe;
        end
    end

    assign sticky_vec = sticky_q;
`endif

    assign src_i.in_ready = rdy_q;
    assign str_arr        = win_q;
    assign ALU            = alu_q;
    assign en             = en_q;
    assign issue          = issue_q;
    assign match_valid    = mv_q;
    assign match_vec      = mvec_q;
    assign match_pos      = mpos_q;
    assign busy           = (state_q != IDLE) | issue_q | (|pv_q);
endmodule

// File: doc/str_feeder.md
Name: str_feeder

Overview:
- Upstream stage of the PE router.
- Accepts a byte stream over a valid/ready handshake and maintains a sliding window of the last `num` characters.
- Drives the router's string, ALU-mode and enable vectors, then collects the per-PE result vector after a fixed PE latency.
- Reports each non-zero result with the stream position of the window that produced it.

Parameters:
- DWIDTH, 8, character width in bits.
- num, 16, number of PEs / window slots.
- PE_LAT, 1, cycles from issue to the matching result_from_pe being valid (1..8).
- CNT_W, 16, width of the stream position counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  input byte valid.
- in_data  input  DWIDTH  input byte.
- in_last  input  1  marks the final byte of a stream.
- in_ready  output  1  byte accepted when in_valid & in_ready.
- cfg_we  input  1  load alu_cfg.
- alu_cfg  input  num  per-PE ALU mode bits.
- str_arr  output  num*DWIDTH  window to router; slot i = bits [i*DWIDTH +: DWIDTH].
- ALU  output  num  per-PE ALU mode bits to router.
- en  output  num  per-PE enable to router.
- issue  output  1  one-cycle strobe: str_arr/en hold a new window this cycle.
- result_from_pe  input  num  PE result vector, valid PE_LAT cycles after issue.
- match_valid  output  1  one-cycle strobe: non-zero result captured.
- match_vec  output  num  captured result vector.
- match_pos  output  CNT_W  stream index of the newest byte of the matching window.
- busy  output  1  high in FILL or DRAIN, or while results are outstanding.

Behaviour:
- Reset, asynchronous:
  - Outputs: str_arr=0, en=0, ALU=0, issue=0, match_valid=0, match_vec=0, match_pos=0, busy=0, in_ready=0.
  - Internal: position counter=0, issue pipeline=0, state=IDLE.
  - Reset mid-stream discards the window and all outstanding results; no match_valid may follow reset.
- ALU register:
  - cfg_we loads alu_cfg on the clock edge.
  - Writes are honoured only in IDLE; ignored otherwise.
  - ALU output equals this register.
- FSM states: IDLE, FILL, DRAIN.
  - IDLE: in_ready=1. An accepted byte goes to FILL, or straight to DRAIN if in_last is set on that byte.
  - FILL: in_ready=1. Accepting a byte with in_last goes to DRAIN.
  - DRAIN: in_ready=0. Shifts in zero bytes for num-1 cycles, then waits until the issue pipeline is empty, then returns to IDLE.
  - A single-byte stream still performs the full num-1 drain.
- Window update, on each accepted byte or drain step:
  - Slot i+1 ← slot i; slot 0 ← new byte (0 in DRAIN).
  - en shifts the same way, with en[0] ← 1 for a real byte and 0 for a drain step.
  - issue=1 in the cycle after the update; outputs are registered with 1-cycle latency from acceptance.
  - No accepted byte and no drain step → issue=0, str_arr/en hold.
  - On entry to IDLE, en clears to 0; str_arr holds.
- Position counter:
  - Increments per accepted byte and wraps modulo 2^CNT_W.
  - Resets to 0 at the first byte of each stream.
  - The position is tagged with each issue; drain steps carry the last byte's position.
- Result capture:
  - A PE_LAT-deep shift register carries (issue, position).
  - When its tail is set, result_from_pe is sampled.
  - If the sample is non-zero: the next cycle match_valid=1, match_vec=sample, match_pos=tag.
  - A zero sample produces no strobe.
  - match_vec/match_pos hold until the next strobe.
- Back-pressure: none downstream; one issue per cycle is sustained at full rate.
- Simultaneous events:
  - A new stream byte cannot arrive during DRAIN, since in_ready=0.
  - A cfg_we arriving together with an accepted IDLE byte is applied.

Optional Feature:
- Macro: STR_FEEDER_STICKY_EN.
- Defined:
  - Adds output sticky_vec (num): OR of all sampled result vectors since stream start.
  - Cleared on the first byte of a stream and on reset.
  - Valid for the previous stream while in IDLE.
- Undefined: the port and register are absent; all other behaviour is identical.

Test Plan:
- Reset asserted mid-FILL with 3 bytes accepted → all outputs 0 immediately; no match_valid afterwards; next stream starts at match_pos 0.
- num=16, stream "ABC" with in_last on 'C' → issues at cycles +1,+2,+3, then 15 drain issues. After the 'C' issue: en=0x0007, slot0='C', slot2='A'. Final drain issue en=0x8000. in_ready=0 throughout DRAIN.
- PE_LAT=2, result_from_pe=0x0004 two cycles after the issue of byte index 5 → match_valid one cycle later, match_vec=0x0004, match_pos=5. Zero results produce no strobe.
- in_valid toggled every other cycle over 20 bytes → exactly 20 FILL issues, positions 0..19. cfg_we=0xFFFF attempted mid-stream → ALU unchanged.
- CNT_W=4, 18-byte stream → match_pos wraps 15→0→1.
- STR_FEEDER_STICKY_EN set, results 0x0001 then 0x0100 → sticky_vec=0x0101 in IDLE; first byte of the next stream clears it to 0.
